// File: rtl/sum_accum_pkg.sv
// Shared types and default sizing for the sum_accum block and its interface.
// Counter width covers block lengths up to 65535 samples.
package sum_accum_pkg;

    localparam int IN_W_DEF  = 17;
    localparam int ACC_W_DEF = 24;
    localparam int COUNT_DEF = 16;
    localparam int CNT_W     = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/sum_accum_if.sv
// Sample-in / total-out handshake bundle for sum_accum; valid/ready on both sides.
// slave = accumulator side, master = producer/consumer side.
interface sum_accum_if
    import sum_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/sum_accum_sat_add.sv
// Unsigned W-bit adder with carry-out; combinational, no backpressure.
// SUM_ACCUM_SAT_EN clamps the sum to all-ones on carry, otherwise it wraps.
module sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[W];

`ifdef SUM_ACCUM_SAT_EN
    assign sum = carry ? {W{1'b1}} : full[W-1:0];
`else
    assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/sum_accum.sv
// Sums COUNT samples per block; total is valid one cycle after the last beat and held until taken.
// in_ready is low while a total waits; wrap or saturate chosen by SUM_ACCUM_SAT_EN.
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int COUNT = COUNT_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    sum_accum_if.slave bus
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_vld_q, out_vld_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               last_beat;

    assign in_ext    = ACC_W'(bus.in_data);
    assign last_beat = (cnt_q == CNT_W'(COUNT - 1));

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a     (acc_q),
        .b     (in_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        // clr wins over any beat or output handshake on the same edge
        if (clr) begin
            state_d   = ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            out_vld_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + 1'b1;
                        ovf_d = ovf_q | add_carry;
                        if (last_beat) begin
                            out_data_d = add_sum;
                            out_ovf_d  = ovf_q | add_carry;
                            out_vld_d  = 1'b1;
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_vld_d = 1'b0;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule
